// File: rtl/fxp_mult_arbiter.sv
// Two-requester round-robin front end for a single shared fixed-point multiplier.
// Operands and the full-precision product are registered; results return tagged with the issuing requester.

module fixedpoint_multiplier #(
  parameter int WI1 = 4,
  parameter int WF1 = 5,
  parameter int WI2 = 3,
  parameter int WF2 = 3,
  parameter int WIO = WI1 + WI2,
  parameter int WFO = WF1 + WF2
) (
  input  logic [WI1+WF1-1:0] a,
  input  logic [WI2+WF2-1:0] b,
  output logic [WIO+WFO-1:0] p
);
  localparam int WA = WI1 + WF1;
  localparam int WB = WI2 + WF2;
  localparam int WO = WIO + WFO;

  logic signed [WO-1:0] a_ext;
  logic signed [WO-1:0] b_ext;

  // Both operands are sign-extended to the product width, so the product never overflows
  assign a_ext = {{(WO-WA){a[WA-1]}}, a};
  assign b_ext = {{(WO-WB){b[WB-1]}}, b};
  assign p     = a_ext * b_ext;
endmodule

// state | meaning
// IDLE  | waiting for a request; grant and latch operands in the same cycle
// MULT  | registered operands drive the multiplier; product captured at cycle end
// RESP  | out_valid high, result held until out_ready
module fxp_mult_arbiter #(
  parameter int WI1   = 4,
  parameter int WF1   = 5,
  parameter int WI2   = 3,
  parameter int WF2   = 3,
  parameter int WIO   = WI1 + WI2,
  parameter int WFO   = WF1 + WF2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [WI1+WF1-1:0]     req_a0,
  input  logic [WI1+WF1-1:0]     req_a1,
  input  logic [WI2+WF2-1:0]     req_b0,
  input  logic [WI2+WF2-1:0]     req_b1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIO+WFO-1:0]     out_data,
  output logic                   out_id,
  output logic                   busy,
  output logic [CNT_W-1:0]       op_count
);
  localparam int WA = WI1 + WF1;
  localparam int WB = WI2 + WF2;
  localparam int WO = WIO + WFO;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic          last_grant;
  logic          grant_id;
  logic          grant_en;
  logic          op_id;
  logic [WA-1:0] op_a;
  logic [WB-1:0] op_b;
  logic [WO-1:0] product;

  // Under contention the requester not served last wins
  always_comb begin
    grant_id = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

  // rst gates the accept strobe so nothing is handshaken while reset is held
  assign grant_en  = !rst && (state == IDLE) && (|req_valid);
  assign req_ready = grant_en ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign out_valid = (state == RESP);
  assign busy      = (state != IDLE);

  fixedpoint_multiplier #(
    .WI1 (WI1),
    .WF1 (WF1),
    .WI2 (WI2),
    .WF2 (WF2),
    .WIO (WIO),
    .WFO (WFO)
  ) u_mult (
    .a (op_a),
    .b (op_b),
    .p (product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      out_data   <= '0;
      out_id     <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_en) begin
            op_a       <= grant_id ? req_a1 : req_a0;
            op_b       <= grant_id ? req_b1 : req_b0;
            op_id      <= grant_id;
            last_grant <= grant_id;
            state      <= MULT;
          end
        end
        MULT: begin
          out_data <= product;
          out_id   <= op_id;
          state    <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            op_count <= op_count + CNT_W'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fxp_mult_arbiter.md
# fxp_mult_arbiter

Two-requester arbiter and sequencer for one shared `fixedpoint_multiplier` instance. It accepts signed fixed-point operand pairs from two clients over valid/ready handshakes and grants the multiplier round-robin. It registers operands and the full-precision product, and returns each result with the ID of the requester that issued it. It sits between the datapath clients and the combinational multiplier, so only one multiplier is needed per datapath.

## Interface
- `WI1`, 4, integer bits of operand A (sign included)
- `WF1`, 5, fraction bits of operand A
- `WI2`, 3, integer bits of operand B (sign included)
- `WF2`, 3, fraction bits of operand B
- `WIO`, WI1+WI2, integer bits of product
- `WFO`, WF1+WF2, fraction bits of product
- `CNT_W`, 16, width of completed-operation counter

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid[1:0]`  in  2  per-requester operand valid
- `req_ready[1:0]`  out  2  per-requester accept strobe
- `req_a0`, `req_a1`  in  WI1+WF1  signed operand A of requester 0 / 1
- `req_b0`, `req_b1`  in  WI2+WF2  signed operand B of requester 0 / 1
- `out_valid`  out  1  product valid
- `out_ready`  in  1  consumer accepts product
- `out_data`  out  WIO+WFO  signed product, WFO fraction bits
- `out_id`  out  1  requester that issued `out_data`
- `busy`  out  1  high whenever state ≠ IDLE
- `op_count`  out  CNT_W  completed (consumed) results, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, MULT, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid` is set, grant one requester and assert its `req_ready` combinationally in the same cycle. The other `req_ready` stays 0.
  - Latch the granted operands and ID on the clock edge, then go to MULT.
  - With no valid request, stay in IDLE.
- Arbitration:
  - With one requester valid, it wins.
  - With both valid, the requester not granted last wins.
  - The `last_grant` register resets to 1, so requester 0 wins the first contention.
  - `last_grant` updates only on a grant.
- MULT: the registered operands drive `fixedpoint_multiplier`. Its product is registered into `out_data`, then the FSM goes to RESP.
- RESP:
  - `out_valid` = 1. `out_data` and `out_id` are held stable until `out_ready` = 1.
  - On `out_valid & out_ready`: go to IDLE, and increment `op_count`.
- `req_ready` is 0 in MULT and RESP. A new grant is possible in the cycle after the output handshake.
- Requesters must hold `req_valid` and operands stable until `req_ready`. Deasserting `req_valid` before the grant is legal and withdraws the request.
- Arithmetic: full-precision signed product, two's complement, no rounding or saturation. Width is exactly WIO+WFO, which cannot overflow.
- Reset values: `req_ready` = 0, `out_valid` = 0, `out_data` = 0, `out_id` = 0, `busy` = 0, `op_count` = 0, `last_grant` = 1.

## Timing
- Grant (handshake) at cycle N: operands registered at the end of N; state MULT in cycle N+1.
- Product registered at the end of N+1; `out_valid` = 1 from cycle N+2.
- Latency from request handshake to `out_valid` is 2 cycles.
- Minimum issue interval is 3 cycles, achieved when `out_ready` is held high.
- `out_ready` held low stalls the FSM in RESP indefinitely. No requests are accepted and no data changes during the stall.
- `out_ready` asserted while `out_valid` = 0 has no effect.
- Reset asserted mid-operation, in any cycle:
  - All outputs take their reset values immediately (asynchronously).
  - The in-flight operation is dropped and `op_count` is not incremented.
  - `req_ready` is 0 while `rst` = 1.
- Reset released with requests pending: the first grant happens in the first cycle after release, with requester 0 preferred.
- `op_count` at 2^CNT_W−1 plus one more completion wraps to 0.

## Test plan
- Single request on requester 0, A=9'sd148 (4.625), B=6'sd29 (3.625), `out_ready`=1 -> `out_valid` 2 cycles after grant with `out_data`=16'h10C4 (16.765625), `out_id`=0, `op_count`=1.
- Signed request on requester 1, A=9'h1C0 (−2.0), B=6'h0C (1.5) -> `out_data`=16'hFD00 (−3.0), `out_id`=1.
- Both requesters held valid continuously, `out_ready`=1 -> grants alternate 0,1,0,1. One result every 3 cycles, `out_id` alternating, starting with 0.
- Output stall: hold `out_ready`=0 for 10 cycles in RESP -> `out_data` and `out_id` stable, `req_ready`=2'b00 throughout, `op_count` unchanged. Release -> count increments and the next grant occurs the following cycle.
- Reset pulse in the MULT cycle -> `out_valid` is never asserted for that operation, and all outputs are 0. After release, a pending dual request is granted to requester 0.
- Extreme operands A=9'h100 (−8.0), B=6'h20 (−4.0) -> `out_data`=16'h2000 (+32.0), with no overflow.
